// File: rtl/keypad_pkg.sv
// Shared types for the 4x3 matrix keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DEBOUNCE,
        DONE
    } state_t;

    typedef logic [1:0] row_idx_t;
    typedef logic [1:0] col_idx_t;

    // Lowest-index column reading low; callers only use it when some column is low.
    function automatic col_idx_t lowest_low_col(input logic [NUM_COLS-1:0] cols);
        col_idx_t idx;
        idx = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (!cols[c]) idx = col_idx_t'(c);
        end
        return idx;
    endfunction

    function automatic logic [NUM_ROWS-1:0] row_drive(input row_idx_t row);
        return ~(NUM_ROWS'(1) << row);
    endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer, parameterized width and reset value.
module keypad_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner; optional debounce stage enabled by KEYPAD_DEBOUNCE_EN.
//  state    | meaning
//  IDLE     | rows released, waiting for a start edge
//  SCAN     | one row driven low per ROW_CYCLES dwell, cols sampled at dwell end
//  DEBOUNCE | candidate key held; same column must stay low DEBOUNCE_CYCLES clocks
//  DONE     | rows released, dataReady high, indices held until next start edge
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROW_CYCLES      = 8,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [NUM_COLS-1:0] cols,
    output logic [NUM_ROWS-1:0] rows,
    output logic                dataReady,
    output logic [31:0]         foundRow,
    output logic [31:0]         foundCol
);

    localparam int CNT_MAX = (ROW_CYCLES > DEBOUNCE_CYCLES) ? ROW_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t ROW_LOAD = cnt_t'(ROW_CYCLES - 1);
`ifdef KEYPAD_DEBOUNCE_EN
    localparam cnt_t DEB_LOAD = cnt_t'(DEBOUNCE_CYCLES - 1);
    col_idx_t cand_col_q;
`endif

    logic                start_s;
    logic [NUM_COLS-1:0] cols_s;
    logic                start_prev_q;
    logic                start_rise;

    state_t              state_q;
    row_idx_t            row_q;
    cnt_t                cnt_q;
    logic [NUM_ROWS-1:0] rows_q;
    logic                data_ready_q;
    row_idx_t            found_row_q;
    col_idx_t            found_col_q;

    keypad_sync2 #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_start (
        .clock   (clock),
        .reset_n (reset_n),
        .d_i     (start),
        .q_o     (start_s)
    );

    keypad_sync2 #(.WIDTH(NUM_COLS), .RESET_VAL({NUM_COLS{1'b1}})) u_sync_cols (
        .clock   (clock),
        .reset_n (reset_n),
        .d_i     (cols),
        .q_o     (cols_s)
    );

    assign start_rise = start_s & ~start_prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_prev_q <= 1'b0;
            state_q      <= IDLE;
            row_q        <= '0;
            cnt_q        <= '0;
            rows_q       <= '1;
            data_ready_q <= 1'b0;
            found_row_q  <= '0;
            found_col_q  <= '0;
`ifdef KEYPAD_DEBOUNCE_EN
            cand_col_q   <= '0;
`endif
        end else begin
            start_prev_q <= start_s;
            // A start edge wins over everything, including a sample due this cycle.
            if (start_rise) begin
                state_q      <= SCAN;
                row_q        <= '0;
                cnt_q        <= ROW_LOAD;
                rows_q       <= row_drive('0);
                data_ready_q <= 1'b0;
            end else begin
                case (state_q)
                    SCAN: begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - cnt_t'(1);
                        end else if (cols_s != '1) begin
`ifdef KEYPAD_DEBOUNCE_EN
                            state_q    <= DEBOUNCE;
                            cand_col_q <= lowest_low_col(cols_s);
                            cnt_q      <= DEB_LOAD;
`else
                            state_q      <= DONE;
                            found_row_q  <= row_q;
                            found_col_q  <= lowest_low_col(cols_s);
                            rows_q       <= '1;
                            data_ready_q <= 1'b1;
`endif
                        end else begin
                            row_q  <= row_q + row_idx_t'(1);
                            cnt_q  <= ROW_LOAD;
                            rows_q <= row_drive(row_q + row_idx_t'(1));
                        end
                    end
`ifdef KEYPAD_DEBOUNCE_EN
                    DEBOUNCE: begin
                        if (!cols_s[cand_col_q]) begin
                            if (cnt_q == '0) begin
                                state_q      <= DONE;
                                found_row_q  <= row_q;
                                found_col_q  <= cand_col_q;
                                rows_q       <= '1;
                                data_ready_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q - cnt_t'(1);
                            end
                        end else begin
                            state_q <= SCAN;
                            row_q   <= row_q + row_idx_t'(1);
                            cnt_q   <= ROW_LOAD;
                            rows_q  <= row_drive(row_q + row_idx_t'(1));
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign rows      = rows_q;
    assign dataReady = data_ready_q;
    assign foundRow  = {30'b0, found_row_q};
    assign foundCol  = {30'b0, found_col_q};

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner; covers KEYPAD_DEBOUNCE_EN when defined.
module tb_keypad_scanner;

    localparam int ROW_CYCLES      = 8;
    localparam int DEBOUNCE_CYCLES = 1000;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DEB_EXTRA = DEBOUNCE_CYCLES + 2;
`else
    localparam int DEB_EXTRA = 0;
`endif

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [2:0]  cols;
    logic [3:0]  rows;
    logic        dataReady;
    logic [31:0] foundRow;
    logic [31:0] foundCol;

    // key_map[r] bit c set means the key at row r, column c is pressed
    logic [2:0]  key_map [4];

    int checks = 0;
    int errors = 0;
    int exp_row = 0;
    int exp_col = 0;

    keypad_scanner #(.ROW_CYCLES(ROW_CYCLES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .cols      (cols),
        .rows      (rows),
        .dataReady (dataReady),
        .foundRow  (foundRow),
        .foundCol  (foundCol)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Passive keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        cols = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (!rows[r]) cols = cols & ~key_map[r];
        end
    end

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) key_map[r] = 3'b000;
    endtask

    // Raises start, drops it after three cycles, waits for a fresh dataReady.
    task automatic run_scan(input int budget, output bit seen, output int lat, output logic dr_at4);
        @(negedge clock);
        start = 1'b1;
        seen = 1'b0;
        lat = budget + 1;
        dr_at4 = 1'bx;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clock);
            if (i == 3) start = 1'b0;
            if (i == 4) dr_at4 = dataReady;
            if (i >= 4 && dataReady) begin
                seen = 1'b1;
                lat = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_rows(input logic [3:0] want, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (rows == want) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Reference model: scan starts at row 0, first row with any key wins, lowest column in it.
    task automatic check_scan(input string name);
        bit    seen;
        int    lat;
        int    bound;
        logic  dr_at4;
        exp_row = -1;
        exp_col = 0;
        for (int r = 0; r < 4; r++) begin
            if (exp_row < 0 && key_map[r] != 3'b000) begin
                exp_row = r;
                for (int c = 2; c >= 0; c--) if (key_map[r][c]) exp_col = c;
            end
        end
        bound = (exp_row + 1) * ROW_CYCLES + 4 + DEB_EXTRA;
        run_scan(bound + 20, seen, lat, dr_at4);
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: dataReady got %b want 1", name, seen);
        end
        checks++;
        if (lat > bound) begin
            errors++;
            $display("FAIL %s latency: got %0d want <= %0d", name, lat, bound);
        end
        checks++;
        if (dr_at4 !== 1'b0) begin
            errors++;
            $display("FAIL %s clear: dataReady after start got %b want 0", name, dr_at4);
        end
        checks++;
        if (foundRow !== 32'(exp_row)) begin
            errors++;
            $display("FAIL %s foundRow: got %0d want %0d", name, foundRow, exp_row);
        end
        checks++;
        if (foundCol !== 32'(exp_col)) begin
            errors++;
            $display("FAIL %s foundCol: got %0d want %0d", name, foundCol, exp_col);
        end
        checks++;
        if (rows !== 4'b1111) begin
            errors++;
            $display("FAIL %s rows: got %b want 1111", name, rows);
        end
    endtask

    task automatic test_reset();
        clear_keys();
        start = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks += 4;
        if (rows !== 4'b1111)   begin errors++; $display("FAIL reset rows: got %b want 1111", rows); end
        if (dataReady !== 1'b0) begin errors++; $display("FAIL reset dataReady: got %b want 0", dataReady); end
        if (foundRow !== 32'd0) begin errors++; $display("FAIL reset foundRow: got %0d want 0", foundRow); end
        if (foundCol !== 32'd0) begin errors++; $display("FAIL reset foundCol: got %0d want 0", foundCol); end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single_key();
        clear_keys();
        key_map[1] = 3'b010;
        check_scan("single_key");
    endtask

    task automatic test_multi_key();
        clear_keys();
        key_map[3] = 3'b101;
        check_scan("multi_key");
    endtask

    task automatic test_no_key();
        logic [3:0] seq[$];
        logic [3:0] prev;
        logic [3:0] want [5];
        bit         dr_seen;
        want[0] = 4'b1110; want[1] = 4'b1101; want[2] = 4'b1011; want[3] = 4'b0111; want[4] = 4'b1110;
        clear_keys();
        dr_seen = 1'b0;
        @(negedge clock);
        start = 1'b1;
        prev = rows;
        for (int i = 1; i <= 5 * ROW_CYCLES + 10; i++) begin
            @(negedge clock);
            if (i == 3) start = 1'b0;
            if (i >= 4 && dataReady) dr_seen = 1'b1;
            if (rows != prev) seq.push_back(rows);
            prev = rows;
        end
        checks++;
        if (seq.size() < 5) begin
            errors++;
            $display("FAIL no_key row_changes: got %0d want >= 5", seq.size());
        end
        for (int k = 0; k < 5 && k < seq.size(); k++) begin
            checks++;
            if (seq[k] !== want[k]) begin
                errors++;
                $display("FAIL no_key rows[%0d]: got %b want %b", k, seq[k], want[k]);
            end
        end
        checks++;
        if (dr_seen !== 1'b0) begin
            errors++;
            $display("FAIL no_key dataReady: got 1 want 0");
        end
    endtask

    task automatic test_restart();
        bit seen;
        clear_keys();
        wait_rows(4'b1011, 5 * ROW_CYCLES, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL restart reach_row2: got no 1011 want 1011"); end
        @(negedge clock);
        start = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0;
        wait_rows(4'b1110, 6, seen);
        checks += 3;
        if (!seen) begin errors++; $display("FAIL restart rows: got %b want 1110", rows); end
        if (dataReady !== 1'b0) begin errors++; $display("FAIL restart dataReady: got %b want 0", dataReady); end
        if (foundRow !== 32'(exp_row)) begin errors++; $display("FAIL restart foundRow: got %0d want %0d", foundRow, exp_row); end
    endtask

    task automatic test_start_held();
        bit seen;
        clear_keys();
        key_map[2] = 3'b100;
        @(negedge clock);
        start = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= 3 * ROW_CYCLES + 30 + DEB_EXTRA; i++) begin
            @(negedge clock);
            if (i >= 4 && dataReady) begin seen = 1'b1; break; end
        end
        key_map[0] = 3'b001;
        repeat (6 * ROW_CYCLES) @(negedge clock);
        checks += 4;
        if (!seen)              begin errors++; $display("FAIL held timeout: dataReady got 0 want 1"); end
        if (dataReady !== 1'b1) begin errors++; $display("FAIL held dataReady: got %b want 1", dataReady); end
        if (foundRow !== 32'd2) begin errors++; $display("FAIL held foundRow: got %0d want 2", foundRow); end
        if (rows !== 4'b1111)   begin errors++; $display("FAIL held rows: got %b want 1111", rows); end
        start = 1'b0;
        exp_row = 2;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_midscan();
        bit seen;
        clear_keys();
        @(negedge clock);
        start = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0;
        wait_rows(4'b1011, 4 * ROW_CYCLES, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL midreset reach_row2: got %b want 1011", rows); end
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        checks += 3;
        if (rows !== 4'b1111)   begin errors++; $display("FAIL midreset rows: got %b want 1111", rows); end
        if (dataReady !== 1'b0) begin errors++; $display("FAIL midreset dataReady: got %b want 0", dataReady); end
        if (foundRow !== 32'd0) begin errors++; $display("FAIL midreset foundRow: got %0d want 0", foundRow); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_random();
        bit any;
        for (int t = 0; t < 16; t++) begin
            any = 1'b0;
            for (int r = 0; r < 4; r++) begin
                key_map[r] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
                if (key_map[r] != 3'b000) any = 1'b1;
            end
            if (!any) key_map[$urandom_range(0, 3)] = 3'($urandom_range(1, 7));
            check_scan("random");
        end
    endtask

`ifdef KEYPAD_DEBOUNCE_EN
    task automatic test_debounce();
        bit seen;
        bit dr_seen;
        clear_keys();
        key_map[2] = 3'b100;
        @(negedge clock);
        start = 1'b1;
        repeat (3) @(negedge clock);
        start = 1'b0;
        wait_rows(4'b1011, 4 * ROW_CYCLES, seen);
        checks++;
        if (!seen) begin errors++; $display("FAIL debounce reach_row2: got %b want 1011", rows); end
        dr_seen = 1'b0;
        repeat (ROW_CYCLES + DEBOUNCE_CYCLES / 2) begin
            @(negedge clock);
            if (dataReady) dr_seen = 1'b1;
        end
        key_map[2] = 3'b000;
        repeat (3 * ROW_CYCLES) begin
            @(negedge clock);
            if (dataReady) dr_seen = 1'b1;
        end
        checks++;
        if (dr_seen !== 1'b0) begin errors++; $display("FAIL debounce bounce: dataReady got 1 want 0"); end
        key_map[2] = 3'b100;
        seen = 1'b0;
        for (int i = 0; i < 5 * ROW_CYCLES + DEBOUNCE_CYCLES + 20; i++) begin
            @(negedge clock);
            if (dataReady) begin seen = 1'b1; break; end
        end
        checks += 3;
        if (!seen)              begin errors++; $display("FAIL debounce timeout: dataReady got 0 want 1"); end
        if (foundCol !== 32'd2) begin errors++; $display("FAIL debounce foundCol: got %0d want 2", foundCol); end
        if (foundRow !== 32'd2) begin errors++; $display("FAIL debounce foundRow: got %0d want 2", foundRow); end
    endtask
`endif

    initial begin
        clear_keys();
        start = 1'b0;
        reset_n = 1'b0;
        test_reset();
        test_single_key();
        test_multi_key();
        test_no_key();
        test_restart();
        test_start_held();
        test_reset_midscan();
        test_random();
`ifdef KEYPAD_DEBOUNCE_EN
        test_debounce();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
